// File: rtl/vscale_htif_host_poller.sv
// Host-side HTIF PCR initiator: polls to_host, forwards nonzero words on a
// valid/ready stream, and writes host-supplied words to from_host.
// Optional feature macro: VSCALE_HTIF_TIMEOUT_EN (bounded wait with sticky abort flag).
module vscale_htif_host_poller #(
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_wr_valid,
  output logic        host_wr_ready,
  input  logic [63:0] host_wr_data,
  output logic        tohost_valid,
  input  logic        tohost_ready,
  output logic [63:0] tohost_data,
  output logic        htif_pcr_req_valid,
  input  logic        htif_pcr_req_ready,
  output logic        htif_pcr_req_rw,
  output logic [11:0] htif_pcr_req_addr,
  output logic [63:0] htif_pcr_req_data,
  input  logic        htif_pcr_resp_valid,
  output logic        htif_pcr_resp_ready,
  input  logic [63:0] htif_pcr_resp_data,
  output logic        busy,
  output logic        timeout
);

  localparam logic [11:0]    ADDR_TO_HOST   = 12'h780;
  localparam logic [11:0]    ADDR_FROM_HOST = 12'h781;
  localparam int unsigned    PCW            = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PCW-1:0] POLL_RELOAD    = PCW'(POLL_INTERVAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DELIVER} state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic           req_rw_q, req_rw_d;
  logic [11:0]    req_addr_q, req_addr_d;
  logic [63:0]    req_data_q, req_data_d;
  logic [63:0]    tohost_data_q, tohost_data_d;

`ifdef VSCALE_HTIF_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        abort;

  // Abort when the wait bound is hit without a completing handshake this cycle.
  always_comb begin
    abort = 1'b0;
    if (wait_cnt_q >= 16'(TIMEOUT_CYCLES - 1)) begin
      abort = ((state_q == S_REQ)  && !htif_pcr_req_ready) ||
              ((state_q == S_RESP) && !htif_pcr_resp_valid);
    end
  end
`endif

  // Next-state and request/capture register updates.
  always_comb begin
    state_d       = state_q;
    poll_cnt_d    = poll_cnt_q;
    req_rw_d      = req_rw_q;
    req_addr_d    = req_addr_q;
    req_data_d    = req_data_q;
    tohost_data_d = tohost_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (host_wr_valid) begin
          req_rw_d   = 1'b1;
          req_addr_d = ADDR_FROM_HOST;
          req_data_d = host_wr_data;
          state_d    = S_REQ;
        end else if (poll_cnt_q == '0) begin
          req_rw_d   = 1'b0;
          req_addr_d = ADDR_TO_HOST;
          req_data_d = '0;
          state_d    = S_REQ;
        end else begin
          poll_cnt_d = poll_cnt_q - 1'b1;
        end
      end
      S_REQ: begin
`ifdef VSCALE_HTIF_TIMEOUT_EN
        if (abort) state_d = S_IDLE;
        else
`endif
        if (htif_pcr_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
`ifdef VSCALE_HTIF_TIMEOUT_EN
        if (abort) state_d = S_IDLE;
        else
`endif
        if (htif_pcr_resp_valid) begin
          if (req_rw_q || (htif_pcr_resp_data == '0)) begin
            state_d = S_IDLE;
          end else begin
            tohost_data_d = htif_pcr_resp_data;
            state_d       = S_DELIVER;
          end
        end
      end
      S_DELIVER: begin
        if (tohost_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) poll_cnt_d = POLL_RELOAD;
  end

`ifdef VSCALE_HTIF_TIMEOUT_EN
  // Wait counter spans S_REQ and S_RESP; the abort flag is sticky until reset.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q == S_IDLE) && (state_d == S_REQ)) wait_cnt_d = '0;
    else if ((state_q == S_REQ) || (state_q == S_RESP)) wait_cnt_d = wait_cnt_q + 1'b1;
    timeout_d = timeout_q | abort;
  end

  // Timeout state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // TIMEOUT_CYCLES has no effect in this build; referenced only so it is not dangling.
  assign timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      poll_cnt_q    <= POLL_RELOAD;
      req_rw_q      <= 1'b0;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      tohost_data_q <= '0;
    end else begin
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      req_rw_q      <= req_rw_d;
      req_addr_q    <= req_addr_d;
      req_data_q    <= req_data_d;
      tohost_data_q <= tohost_data_d;
    end
  end

  assign host_wr_ready       = (state_q == S_IDLE);
  assign htif_pcr_req_valid  = (state_q == S_REQ);
  assign htif_pcr_resp_ready = (state_q == S_RESP);
  assign tohost_valid        = (state_q == S_DELIVER);
  assign busy                = (state_q != S_IDLE);
  assign htif_pcr_req_rw     = req_rw_q;
  assign htif_pcr_req_addr   = req_addr_q;
  assign htif_pcr_req_data   = req_data_q;
  assign tohost_data         = tohost_data_q;

endmodule

// File: tb/tb_vscale_htif_host_poller.sv
// Bench for vscale_htif_host_poller. Expectations come from the transaction
// timing rules: IDLE entry reloads the poll counter, the poll request appears
// POLL_INTERVAL cycles after IDLE entry, and each handshake costs one cycle.
module tb_vscale_htif_host_poller;
  localparam int unsigned PI = 4;
  localparam int unsigned TO = 8;
`ifdef VSCALE_HTIF_TIMEOUT_EN
  localparam int unsigned REQ_HOLD = 3, RESP_HOLD = 3;
`else
  localparam int unsigned REQ_HOLD = 5, RESP_HOLD = 3;
`endif

  logic        clk = 1'b0, reset = 1'b1;
  logic        host_wr_valid = 1'b0, host_wr_ready;
  logic [63:0] host_wr_data = '0;
  logic        tohost_valid, tohost_ready = 1'b0;
  logic [63:0] tohost_data;
  logic        req_valid, req_ready = 1'b0, req_rw;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic        resp_valid = 1'b0, resp_ready;
  logic [63:0] resp_data = '0;
  logic        busy, timeout;

  int total = 0, bad = 0;
  int unsigned req_hs = 0;

  vscale_htif_host_poller #(.POLL_INTERVAL(PI), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_data(host_wr_data),
    .tohost_valid(tohost_valid), .tohost_ready(tohost_ready), .tohost_data(tohost_data),
    .htif_pcr_req_valid(req_valid), .htif_pcr_req_ready(req_ready), .htif_pcr_req_rw(req_rw),
    .htif_pcr_req_addr(req_addr), .htif_pcr_req_data(req_data),
    .htif_pcr_resp_valid(resp_valid), .htif_pcr_resp_ready(resp_ready), .htif_pcr_resp_data(resp_data),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Count request handshakes as the next rising edge will see them.
  always @(negedge clk) if (!reset && req_valid && req_ready) req_hs++;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Leaves the bench at IDLE offset 0 (poll counter freshly loaded).
  task automatic do_reset();
    reset = 1'b1; host_wr_valid = 1'b0; tohost_ready = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    total++; if (resp_ready !== 1'b0) begin bad++; $display("FAIL rst_resp_ready: got %b want 0", resp_ready); end
    total++; if (tohost_valid !== 1'b0) begin bad++; $display("FAIL rst_tohost_valid: got %b want 0", tohost_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    total++; if ({req_rw, req_addr, req_data, tohost_data} !== '0) begin bad++; $display("FAIL rst_regs: got rw=%b addr=%h data=%h th=%h want all 0", req_rw, req_addr, req_data, tohost_data); end
    total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL rst_host_wr_ready: got %b want 1", host_wr_ready); end
  endtask

  task automatic test_idle_poll();
    int unsigned n;
    logic exp;
    do_reset();
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = '0;
    n = 30 + $urandom_range(0, 12);
    for (int unsigned c = 0; c <= n; c++) begin
      exp = (c >= PI) && (((c - PI) % (PI + 2)) == 0);
      total++; if (req_valid !== exp) begin bad++; $display("FAIL poll_timing c=%0d: got %b want %b", c, req_valid, exp); end
      if (exp) begin
        total++; if (req_addr !== 12'h780 || req_rw !== 1'b0 || req_data !== '0) begin bad++; $display("FAIL poll_fields: got addr=%h rw=%b data=%h want 780/0/0", req_addr, req_rw, req_data); end
      end
      total++; if (tohost_valid !== 1'b0) begin bad++; $display("FAIL poll_no_tohost c=%0d: got %b want 0", c, tohost_valid); end
      cyc();
    end
  endtask

  task automatic test_capture();
    logic [63:0] r;
    do_reset();
    req_ready = 1'b1; resp_valid = 1'b1;
    r = {$urandom, $urandom} | 64'h1;
    resp_data = r;
    repeat (PI + 2) cyc();
    resp_data = '0;
    for (int i = 0; i < 10; i++) begin
      total++; if (tohost_valid !== 1'b1 || tohost_data !== r) begin bad++; $display("FAIL capture_hold i=%0d: got v=%b d=%h want 1/%h", i, tohost_valid, tohost_data, r); end
      total++; if (req_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL capture_backpressure i=%0d: got req_valid=%b busy=%b want 0/1", i, req_valid, busy); end
      cyc();
    end
    tohost_ready = 1'b1;
    cyc();
    tohost_ready = 1'b0;
    total++; if (tohost_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL capture_release: got v=%b busy=%b want 0/0", tohost_valid, busy); end
    for (int unsigned k = 0; k <= PI; k++) begin
      total++; if (req_valid !== (k == PI)) begin bad++; $display("FAIL capture_repoll k=%0d: got %b want %b", k, req_valid, (k == PI)); end
      if (k < PI) cyc();
    end
  endtask

  task automatic test_host_write();
    do_reset();
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = '0;
    repeat (PI - 1) cyc();
    total++; if (req_valid !== 1'b0 || host_wr_ready !== 1'b1) begin bad++; $display("FAIL hw_pre: got req_valid=%b wr_ready=%b want 0/1", req_valid, host_wr_ready); end
    host_wr_valid = 1'b1; host_wr_data = 64'hDEAD_BEEF;
    cyc();
    host_wr_valid = 1'b0;
    total++; if (req_valid !== 1'b1 || req_rw !== 1'b1 || req_addr !== 12'h781 || req_data !== 64'hDEAD_BEEF) begin bad++; $display("FAIL hw_req: got v=%b rw=%b addr=%h data=%h want 1/1/781/deadbeef", req_valid, req_rw, req_addr, req_data); end
    resp_data = {$urandom, $urandom} | 64'h1;
    cyc();
    total++; if (resp_ready !== 1'b1) begin bad++; $display("FAIL hw_resp_ready: got %b want 1", resp_ready); end
    cyc();
    resp_data = '0;
    total++; if (busy !== 1'b0 || tohost_valid !== 1'b0) begin bad++; $display("FAIL hw_done: got busy=%b tohost_valid=%b want 0/0", busy, tohost_valid); end
    for (int unsigned k = 0; k <= PI; k++) begin
      total++; if (req_valid !== (k == PI)) begin bad++; $display("FAIL hw_poll_after k=%0d: got %b want %b", k, req_valid, (k == PI)); end
      if (k == PI) begin
        total++; if (req_rw !== 1'b0 || req_addr !== 12'h780) begin bad++; $display("FAIL hw_poll_fields: got rw=%b addr=%h want 0/780", req_rw, req_addr); end
      end
      if (k < PI) cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    int unsigned hs0;
    do_reset();
    d = {$urandom, $urandom};
    host_wr_valid = 1'b1; host_wr_data = d;
    cyc();
    host_wr_valid = 1'b0; host_wr_data = '0;
    hs0 = req_hs;
    for (int unsigned i = 0; i < REQ_HOLD; i++) begin
      total++; if (req_valid !== 1'b1 || req_rw !== 1'b1 || req_addr !== 12'h781 || req_data !== d) begin bad++; $display("FAIL bp_req_stable i=%0d: got v=%b rw=%b addr=%h data=%h want 1/1/781/%h", i, req_valid, req_rw, req_addr, req_data, d); end
      cyc();
    end
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    for (int unsigned i = 0; i < RESP_HOLD; i++) begin
      total++; if (resp_ready !== 1'b1 || req_valid !== 1'b0) begin bad++; $display("FAIL bp_resp_wait i=%0d: got resp_ready=%b req_valid=%b want 1/0", i, resp_ready, req_valid); end
      cyc();
    end
    resp_valid = 1'b1; resp_data = {$urandom, $urandom};
    cyc();
    resp_valid = 1'b0;
    total++; if (busy !== 1'b0 || tohost_valid !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL bp_done: got busy=%b tohost_valid=%b timeout=%b want 0/0/0", busy, tohost_valid, timeout); end
    total++; if (req_hs - hs0 !== 1) begin bad++; $display("FAIL bp_one_txn: got %0d handshakes want 1", req_hs - hs0); end
  endtask

  task automatic test_reset_midop();
    logic [63:0] r;
    do_reset();
    req_ready = 1'b1;
    repeat (PI + 1) cyc();
    total++; if (resp_ready !== 1'b1) begin bad++; $display("FAIL rm_in_resp: got %b want 1", resp_ready); end
    reset = 1'b1; cyc(); reset = 1'b0;
    total++; if ({req_valid, resp_ready, tohost_valid, busy} !== 4'b0) begin bad++; $display("FAIL rm_resp_reset: got %b want 0000", {req_valid, resp_ready, tohost_valid, busy}); end
    for (int unsigned k = 0; k <= PI; k++) begin
      total++; if (req_valid !== (k == PI)) begin bad++; $display("FAIL rm_reload1 k=%0d: got %b want %b", k, req_valid, (k == PI)); end
      if (k < PI) cyc();
    end
    r = {$urandom, $urandom} | 64'h1;
    resp_valid = 1'b1; resp_data = r;
    cyc(); cyc();
    total++; if (tohost_valid !== 1'b1 || tohost_data !== r) begin bad++; $display("FAIL rm_in_deliver: got v=%b d=%h want 1/%h", tohost_valid, tohost_data, r); end
    reset = 1'b1; resp_valid = 1'b0; cyc(); reset = 1'b0;
    total++; if ({req_valid, resp_ready, tohost_valid, busy} !== 4'b0 || tohost_data !== '0) begin bad++; $display("FAIL rm_deliver_reset: got flags=%b d=%h want 0000/0", {req_valid, resp_ready, tohost_valid, busy}, tohost_data); end
    for (int unsigned k = 0; k <= PI; k++) begin
      total++; if (req_valid !== (k == PI)) begin bad++; $display("FAIL rm_reload2 k=%0d: got %b want %b", k, req_valid, (k == PI)); end
      if (k < PI) cyc();
    end
  endtask

`ifdef VSCALE_HTIF_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    repeat (PI) cyc();
    for (int unsigned i = 0; i < TO; i++) begin
      total++; if (req_valid !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL to_wait i=%0d: got v=%b to=%b want 1/0", i, req_valid, timeout); end
      cyc();
    end
    total++; if (req_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b1) begin bad++; $display("FAIL to_abort: got v=%b busy=%b to=%b want 0/0/1", req_valid, busy, timeout); end
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = '0;
    for (int unsigned k = 0; k <= PI; k++) begin
      total++; if (req_valid !== (k == PI)) begin bad++; $display("FAIL to_resume k=%0d: got %b want %b", k, req_valid, (k == PI)); end
      if (k < PI) cyc();
    end
    cyc(); cyc();
    total++; if (busy !== 1'b0 || timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got busy=%b to=%b want 0/1", busy, timeout); end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    repeat (PI) cyc();
    for (int unsigned i = 0; i < 3 * TO; i += 4) begin
      total++; if (req_valid !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL nto_wait i=%0d: got v=%b to=%b want 1/0", i, req_valid, timeout); end
      repeat (4) cyc();
    end
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = '0;
    cyc(); cyc();
    total++; if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL nto_done: got busy=%b to=%b want 0/0", busy, timeout); end
  endtask
`endif

  task automatic test_random();
    logic [63:0] v;
    int unsigned d, h;
    do_reset();
    req_ready = 1'b1; resp_valid = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom_range(0, PI - 1);
        v = {$urandom, $urandom};
        for (int unsigned k = 0; k < d; k++) begin
          total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rnd_w_idle it=%0d: got %b want 0", it, req_valid); end
          cyc();
        end
        host_wr_valid = 1'b1; host_wr_data = v; resp_data = {$urandom, $urandom} | 64'h1;
        cyc();
        host_wr_valid = 1'b0;
        total++; if (req_valid !== 1'b1 || req_rw !== 1'b1 || req_addr !== 12'h781 || req_data !== v) begin bad++; $display("FAIL rnd_w_req it=%0d: got v=%b rw=%b addr=%h data=%h want 1/1/781/%h", it, req_valid, req_rw, req_addr, req_data, v); end
        cyc(); cyc();
      end else begin
        v = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'h0;
        resp_data = v;
        for (int unsigned k = 0; k < PI; k++) begin
          total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rnd_p_idle it=%0d: got %b want 0", it, req_valid); end
          cyc();
        end
        total++; if (req_valid !== 1'b1 || req_rw !== 1'b0 || req_addr !== 12'h780 || req_data !== '0) begin bad++; $display("FAIL rnd_p_req it=%0d: got v=%b rw=%b addr=%h data=%h want 1/0/780/0", it, req_valid, req_rw, req_addr, req_data); end
        cyc(); cyc();
        if (v != '0) begin
          h = $urandom_range(0, 4);
          for (int unsigned j = 0; j <= h; j++) begin
            total++; if (tohost_valid !== 1'b1 || tohost_data !== v) begin bad++; $display("FAIL rnd_deliver it=%0d: got v=%b d=%h want 1/%h", it, tohost_valid, tohost_data, v); end
            if (j == h) tohost_ready = 1'b1;
            cyc();
          end
          tohost_ready = 1'b0;
        end
      end
      total++; if (busy !== 1'b0 || tohost_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle it=%0d: got busy=%b tohost_valid=%b want 0/0", it, busy, tohost_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_poll();
    test_capture();
    test_host_write();
    test_backpressure();
    test_reset_midop();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
